// File: rtl/fetch_ctrl.sv
// Fetch controller between the PC register and decode: issues one instruction-memory request per fetch and presents the word to decode.
// Latency: request to id_valid is at least 2 cycles (grant, then read data). pc_next is combinational.
// Backpressure: the word is held while id_ready is low. With no enable on the PC register, pc_next == pc holds it.
//
// Ports:
//   clk, rst                       clock (rising edge), async active-high reset
//   pc / pc_next                   current pc in, next pc out (feeds the PC register)
//   imem_req/addr/gnt              request handshake (addr = pc)
//   imem_rvalid/rdata              in-order read data, one beat per granted request
//   id_valid/ready/instr/pc        registered instruction to decode
//   redirect_valid/target          taken branch/jump; target bits [1:0] forced to 0
// Optional build macro FETCH_CTRL_PERF_EN adds perf_fetched and perf_stalls counters.
module fetch_ctrl #(
    parameter int n   = 32,
    parameter int IW  = 32,
    parameter int INC = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [n-1:0]  pc,
    output logic [n-1:0]  pc_next,
    output logic          imem_req,
    output logic [n-1:0]  imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [IW-1:0] imem_rdata,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [IW-1:0] id_instr,
    output logic [n-1:0]  id_pc,
    input  logic          redirect_valid,
    input  logic [n-1:0]  redirect_target
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_stalls
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam logic [n-1:0] INC_N = n'(INC);

    logic [2:0] state;
    logic [2:0] state_d;
    logic       load;

    assign imem_req  = (state == S_REQ);
    assign imem_addr = pc;

    always_comb begin
        state_d = state;
        load    = 1'b0;
        pc_next = pc;
        case (state)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                // A request granted in the same cycle as a redirect is still
                // outstanding; its response has to be swallowed in DRAIN.
                if (imem_gnt) state_d = redirect_valid ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (redirect_valid) begin
                        state_d = S_REQ;
                    end else begin
                        load    = 1'b1;
                        pc_next = pc + INC_N;
                        state_d = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    state_d = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (redirect_valid || id_ready) state_d = S_REQ;
            end
            S_DRAIN: begin
                if (imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
        if (redirect_valid) pc_next = {redirect_target[n-1:2], 2'b00};
        // The PC register keeps running during reset; keep it parked.
        if (rst) pc_next = pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            id_valid <= 1'b0;
            id_instr <= '0;
            id_pc    <= '0;
        end else begin
            state    <= state_d;
            // HOLD is only ever entered by a load, so id_valid mirrors it.
            id_valid <= (state_d == S_HOLD);
            if (load) begin
                id_instr <= imem_rdata;
                id_pc    <= pc;
            end
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stalls  <= '0;
        end else begin
            if (id_valid && id_ready) perf_fetched <= perf_fetched + 32'd1;
            if ((state == S_WAIT) || (state == S_DRAIN) || ((state == S_HOLD) && !id_ready))
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic against a transaction-level model.
// Latency: checks are made 2 time units after each rising edge; inputs change 1 unit after the edge.
// Backpressure: id_ready, grants and read-data delays are randomized in the random phase.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, pc_next, imem_addr, imem_rdata, id_instr, id_pc, redirect_target;
    logic        imem_req, imem_gnt, imem_rvalid, id_valid, id_ready, redirect_valid;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_fetched, perf_stalls;
`endif

    always #5 clk = ~clk;

    fetch_ctrl #(.n(32), .IW(32), .INC(4)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_next(pc_next),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target)
`ifdef FETCH_CTRL_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stalls(perf_stalls)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    // Transaction-level model: is the block freshly out of reset, is a
    // request outstanding (and already killed by a redirect), is a word held.
    bit          m_fresh, m_out, m_killed, m_hold;
    logic [31:0] m_instr, m_ipc;
    int unsigned m_fetched, m_stalls;

    function automatic logic m_req();
        return !m_fresh && !m_hold && !m_out;
    endfunction

    function automatic logic [31:0] m_pc_next();
        if (rst) return pc;
        if (redirect_valid) return {redirect_target[31:2], 2'b00};
        if (m_out && !m_killed && imem_rvalid) return pc + 32'd4;
        return pc;
    endfunction

    task automatic m_reset();
        m_fresh = 1'b1; m_out = 1'b0; m_killed = 1'b0; m_hold = 1'b0;
        m_instr = '0; m_ipc = '0; m_fetched = 0; m_stalls = 0;
    endtask

    task automatic clear_inputs();
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        id_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    endtask

    // Advance one clock; the model and the PC register take the inputs
    // that were applied during the cycle just ended.
    task automatic tick();
        logic [31:0] nxt;
        logic        req_pre;
        nxt     = m_pc_next();
        req_pre = m_req();
        @(posedge clk);
        #1;
        if (rst) begin
            m_reset();
        end else begin
            if (m_hold && id_ready) m_fetched++;
            if (m_out || (m_hold && !id_ready)) m_stalls++;
            if (m_hold && (redirect_valid || id_ready)) m_hold = 1'b0;
            if (m_fresh) begin
                m_fresh = 1'b0;
            end else if (req_pre && imem_gnt) begin
                m_out = 1'b1; m_killed = redirect_valid;
            end else if (m_out && imem_rvalid) begin
                m_out = 1'b0;
                if (!m_killed && !redirect_valid) begin
                    m_hold = 1'b1; m_instr = imem_rdata; m_ipc = pc;
                end
            end else if (m_out && redirect_valid) begin
                m_killed = 1'b1;
            end
        end
        pc = nxt;
    endtask

    // Reset with the PC register at rpc; returns with the DUT in IDLE.
    task automatic start(input logic [31:0] rpc);
        rst = 1'b1; clear_inputs(); pc = rpc; m_reset();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear_inputs(); pc = 32'h0; m_reset();
        redirect_valid = 1'b1; redirect_target = 32'h40;
        #1;
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b want 0", imem_req); end
        vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", id_valid); end
        vectors++; if (pc_next !== 32'h0) begin miscompares++; $display("FAIL reset_pc_next got %h want 0", pc_next); end
        vectors++; if (id_instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr got %h want 0", id_instr); end
        vectors++; if (id_pc !== 32'h0) begin miscompares++; $display("FAIL reset_id_pc got %h want 0", id_pc); end
        clear_inputs();
        tick();
        rst = 1'b0;
        #1;
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL idle_req got %b want 0", imem_req); end
        tick(); #1;
        vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL first_req got %b want 1", imem_req); end
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL first_addr got %h want 0", imem_addr); end
    endtask

    task automatic test_basic_fetch();
        start(32'h100);
        tick();
        imem_gnt = 1'b1; #1;
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin miscompares++; $display("FAIL basic_req got %b/%h want 1/100", imem_req, imem_addr); end
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF; #1;
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL basic_wait_req got %b want 0", imem_req); end
        vectors++; if (pc_next !== 32'h104) begin miscompares++; $display("FAIL basic_inc got %h want 104", pc_next); end
        tick();
        imem_rvalid = 1'b0; id_ready = 1'b1; #1;
        vectors++; if (id_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got %b want 1", id_valid); end
        vectors++; if (id_instr !== 32'hDEADBEEF) begin miscompares++; $display("FAIL basic_instr got %h want deadbeef", id_instr); end
        vectors++; if (id_pc !== 32'h100) begin miscompares++; $display("FAIL basic_id_pc got %h want 100", id_pc); end
        vectors++; if (pc_next !== 32'h104) begin miscompares++; $display("FAIL basic_inc_once got %h want 104", pc_next); end
        tick();
        id_ready = 1'b0; #1;
        vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL basic_consumed got %b want 0", id_valid); end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin miscompares++; $display("FAIL basic_next_req got %b/%h want 1/104", imem_req, imem_addr); end
    endtask

    task automatic test_hold_stall();
        start(32'h40);
        tick();
        imem_gnt = 1'b1; tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h12345678; tick();
        imem_rvalid = 1'b0; id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++; if (id_valid !== 1'b1 || id_instr !== 32'h12345678) begin miscompares++; $display("FAIL hold_data[%0d] got %b/%h want 1/12345678", i, id_valid, id_instr); end
            vectors++; if (pc_next !== 32'h44 || imem_req !== 1'b0) begin miscompares++; $display("FAIL hold_pc[%0d] got %h/%b want 44/0", i, pc_next, imem_req); end
            tick();
        end
        id_ready = 1'b1; tick();
        id_ready = 1'b0;
    endtask

    task automatic test_redirect_wait();
        start(32'h80);
        tick();
        imem_gnt = 1'b1; tick();
        imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h203; #1;
        vectors++; if (pc_next !== 32'h200) begin miscompares++; $display("FAIL redir_target got %h want 200", pc_next); end
        tick();
        redirect_valid = 1'b0; #1;
        vectors++; if (pc_next !== 32'h200 || imem_req !== 1'b0) begin miscompares++; $display("FAIL drain_idle got %h/%b want 200/0", pc_next, imem_req); end
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0BAD0; #1;
        vectors++; if (pc_next !== 32'h200) begin miscompares++; $display("FAIL drain_no_inc got %h want 200", pc_next); end
        tick();
        imem_rvalid = 1'b0; #1;
        vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL drain_stale got %b want 0", id_valid); end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin miscompares++; $display("FAIL drain_refetch got %b/%h want 1/200", imem_req, imem_addr); end
        imem_gnt = 1'b1; tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h600D600D; tick();
        imem_rvalid = 1'b0; #1;
        vectors++; if (id_valid !== 1'b1 || id_instr !== 32'h600D600D || id_pc !== 32'h200) begin miscompares++; $display("FAIL redir_fetch got %b/%h/%h want 1/600d600d/200", id_valid, id_instr, id_pc); end
        id_ready = 1'b1; tick();
        id_ready = 1'b0;
    endtask

    task automatic test_redirect_rvalid();
        start(32'h300);
        tick();
        imem_gnt = 1'b1; tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h11112222;
        redirect_valid = 1'b1; redirect_target = 32'h512; #1;
        vectors++; if (pc_next !== 32'h510) begin miscompares++; $display("FAIL redir_rv_pc got %h want 510", pc_next); end
        tick();
        clear_inputs(); #1;
        vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL redir_rv_drop got %b want 0", id_valid); end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h510) begin miscompares++; $display("FAIL redir_rv_req got %b/%h want 1/510", imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        start(32'hFFFFFFFC);
        tick();
        imem_gnt = 1'b1; tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hCAFEF00D; #1;
        vectors++; if (pc_next !== 32'h0) begin miscompares++; $display("FAIL wrap_pc got %h want 0", pc_next); end
        tick();
        imem_rvalid = 1'b0; id_ready = 1'b1; #1;
        vectors++; if (id_valid !== 1'b1 || id_pc !== 32'hFFFFFFFC) begin miscompares++; $display("FAIL wrap_id got %b/%h want 1/fffffffc", id_valid, id_pc); end
        tick();
        id_ready = 1'b0; #1;
`ifdef FETCH_CTRL_PERF_EN
        vectors++; if (perf_fetched !== 32'd1) begin miscompares++; $display("FAIL perf_fetched got %0d want 1", perf_fetched); end
        vectors++; if (perf_stalls !== 32'd1) begin miscompares++; $display("FAIL perf_stalls got %0d want 1", perf_stalls); end
`endif
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_next got %b/%h want 1/0", imem_req, imem_addr); end
    endtask

    task automatic test_random();
        int   delay;
        bit   was_out;
        logic exp_req, exp_valid;
        start($urandom & 32'hFFFF_FFFC);
        delay = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst            = ($urandom_range(0, 199) == 0);
            imem_gnt       = ($urandom_range(0, 2) != 0);
            id_ready       = $urandom_range(0, 1);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_target = $urandom;
            imem_rdata     = $urandom;
            if (m_out) begin
                if (delay > 0) begin imem_rvalid = 1'b0; delay--; end
                else imem_rvalid = 1'b1;
            end else begin
                imem_rvalid = ($urandom_range(0, 7) == 0);
            end
            #1;
            exp_req   = rst ? 1'b0 : m_req();
            exp_valid = rst ? 1'b0 : m_hold;
            vectors++; if (imem_req !== exp_req) begin miscompares++; $display("FAIL rnd_req cyc %0d got %b want %b", cyc, imem_req, exp_req); end
            vectors++; if (imem_addr !== pc) begin miscompares++; $display("FAIL rnd_addr cyc %0d got %h want %h", cyc, imem_addr, pc); end
            vectors++; if (pc_next !== m_pc_next()) begin miscompares++; $display("FAIL rnd_pc_next cyc %0d got %h want %h", cyc, pc_next, m_pc_next()); end
            vectors++; if (id_valid !== exp_valid) begin miscompares++; $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, id_valid, exp_valid); end
            if (exp_valid) begin
                vectors++; if (id_instr !== m_instr || id_pc !== m_ipc) begin miscompares++; $display("FAIL rnd_word cyc %0d got %h/%h want %h/%h", cyc, id_instr, id_pc, m_instr, m_ipc); end
            end
`ifdef FETCH_CTRL_PERF_EN
            vectors++; if (perf_fetched !== (rst ? 32'd0 : m_fetched) || perf_stalls !== (rst ? 32'd0 : m_stalls)) begin
                miscompares++; $display("FAIL rnd_perf cyc %0d got %0d/%0d want %0d/%0d", cyc, perf_fetched, perf_stalls, m_fetched, m_stalls);
            end
`endif
            was_out = m_out;
            tick();
            if (!was_out && m_out) delay = $urandom_range(0, 2);
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired got timeout want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        pc  = '0;
        clear_inputs();
        m_reset();
        @(posedge clk); #1;
        test_reset();
        test_basic_fetch();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
